// File: rtl/eje03_pkg.sv
// eje03_pkg: shared state type and default sizing for the eje03 arbiter
package eje03_pkg;
  localparam int ARB_N = 4;
  localparam int ARB_TIMEOUT = 15;
  typedef enum logic [1:0] {IDLE, SOLICITA, ESPERA, LIBERA} st_arb_t;
endpackage

// File: rtl/prio_rr.sv
// prio_rr: picks the first request at or after ptr, wrapping around
module prio_rr
  import eje03_pkg::*;
#(
  parameter int N = ARB_N,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          valid
);
  logic [N-1:0] rot;
  logic [N-1:0] pick;
  // rotate ptr down to bit 0, keep the lowest set bit, rotate it back
  always_comb begin
    rot = N'({req, req} >> ptr);
    pick = '0;
    for (int i = N - 1; i >= 0; i--) pick = rot[i] ? N'(1) << i : pick;
    win = N'(({pick, pick} << ptr) >> N);
  end
  assign valid = |req;
endmodule

// File: rtl/arbitro_rr_eje03.sv
// arbitro_rr_eje03: round-robin arbiter sharing one eje03 unit among N requesters
module arbitro_rr_eje03
  import eje03_pkg::*;
#(
  parameter int N = ARB_N,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] done,
  output logic         r_o,
  input  logic         a_e_i,
  input  logic         c_i,
  output logic         busy,
  output logic         err
);
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);
  st_arb_t st_q, st_n;
  logic [PW-1:0] ptr_q, ptr_n, ptr_nxt;
  logic [CW-1:0] cnt_q, cnt_n, cnt_inc;
  logic [N-1:0] gnt_n, done_n, win;
  logic r_n, err_n, valid, tmo;
  prio_rr #(.N(N)) u_prio (.req(req), .ptr(ptr_q), .win(win), .valid(valid));
  assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
  assign tmo = cnt_inc == CW'(TIMEOUT);
  assign busy = st_q != IDLE;
  // pointer moves to the slot just after the current winner
  always_comb begin
    ptr_nxt = '0;
    for (int i = 0; i < N; i++) ptr_nxt = gnt[i] ? PW'((i + 1) % N) : ptr_nxt;
  end
  // next state and next registered outputs; c_i is ignored until ESPERA
  always_comb begin
    st_n = st_q;
    ptr_n = ptr_q;
    cnt_n = cnt_q;
    gnt_n = gnt;
    done_n = '0;
    r_n = r_o;
    err_n = 1'b0;
    case (st_q)
      IDLE: if (valid) begin
        st_n = SOLICITA;
        gnt_n = win;
        r_n = 1'b1;
        cnt_n = '0;
      end
      SOLICITA: if (a_e_i) begin
        st_n = ESPERA;
        r_n = 1'b0;
        cnt_n = '0;
      end else if (tmo) begin
        st_n = LIBERA;
        r_n = 1'b0;
        gnt_n = '0;
        err_n = 1'b1;
        ptr_n = ptr_nxt;
      end else cnt_n = cnt_inc;
      ESPERA: if (c_i || tmo) begin
        st_n = LIBERA;
        gnt_n = '0;
        done_n = c_i ? gnt : '0;
        err_n = !c_i;
        ptr_n = ptr_nxt;
      end else cnt_n = cnt_inc;
      default: st_n = IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st_q <= IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      gnt <= '0;
      done <= '0;
      r_o <= 1'b0;
      err <= 1'b0;
    end else begin
      st_q <= st_n;
      ptr_q <= ptr_n;
      cnt_q <= cnt_n;
      gnt <= gnt_n;
      done <= done_n;
      r_o <= r_n;
      err <= err_n;
    end
endmodule

// File: tb/tb_arbitro_rr_eje03.sv
// tb_arbitro_rr_eje03: table-driven transaction checks for the round-robin arbiter
module tb_arbitro_rr_eje03;
  typedef struct {
    string name;
    logic [3:0] req;
    logic drop;
    int ae, c, c2;
    logic [3:0] gnt, dn;
    int errs, evt, idle;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0, r_o, a_e_i = 1'b0, c_i = 1'b0, busy, err;
  logic [3:0] req = '0, gnt, done;
  int total = 0, passed = 0;
  vec_t tv[14];
  vec_t fin;
  arbitro_rr_eje03 #(.N(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .done(done), .r_o(r_o),
    .a_e_i(a_e_i), .c_i(c_i), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic run(input vec_t t);
    int evt = 0, idle = 0, rhi = 0, ghi = 0, errs = 0;
    logic [3:0] dn = '0;
    req = t.req;
    @(negedge clk);
    chk({t.name, ".gnt"}, 32'(gnt), 32'(t.gnt));
    chk({t.name, ".busy"}, 32'(busy), 32'd1);
    if (t.drop) req = '0;
    for (int cy = 1; cy <= 40; cy++) begin
      if (!busy) begin
        idle = cy;
        break;
      end
      rhi += int'(r_o);
      ghi += int'(gnt == t.gnt);
      if (|done) begin
        dn |= done;
        if (evt == 0) evt = cy;
      end
      if (err) begin
        errs++;
        if (evt == 0) evt = cy;
      end
      a_e_i = (cy == t.ae);
      c_i = (cy == t.c) || (cy == t.c2);
      @(negedge clk);
    end
    a_e_i = 1'b0;
    c_i = 1'b0;
    req = '0;
    chk({t.name, ".done"}, 32'(dn), 32'(t.dn));
    chk({t.name, ".err"}, 32'(errs), 32'(t.errs));
    chk({t.name, ".evt_cycle"}, 32'(evt), 32'(t.evt));
    chk({t.name, ".idle_cycle"}, 32'(idle), 32'(t.idle));
    chk({t.name, ".r_o_cycles"}, 32'(rhi), 32'(t.ae > 0 ? t.ae : 15));
    chk({t.name, ".gnt_cycles"}, 32'(ghi), 32'(t.evt - 1));
  endtask
  initial begin
    tv[0]  = '{"rr0",      4'b1111, 1'b0, 1, 2,  0, 4'b0001, 4'b0001, 0, 3,  4};
    tv[1]  = '{"rr1",      4'b1111, 1'b0, 1, 2,  0, 4'b0010, 4'b0010, 0, 3,  4};
    tv[2]  = '{"rr2",      4'b1111, 1'b0, 1, 2,  0, 4'b0100, 4'b0100, 0, 3,  4};
    tv[3]  = '{"rr3",      4'b1111, 1'b0, 1, 2,  0, 4'b1000, 4'b1000, 0, 3,  4};
    tv[4]  = '{"rr4",      4'b1111, 1'b0, 1, 2,  0, 4'b0001, 4'b0001, 0, 3,  4};
    tv[5]  = '{"single0",  4'b0001, 1'b1, 2, 5,  0, 4'b0001, 4'b0001, 0, 6,  7};
    tv[6]  = '{"to_ptr3",  4'b0100, 1'b0, 1, 2,  0, 4'b0100, 4'b0100, 0, 3,  4};
    tv[7]  = '{"wrap3",    4'b1010, 1'b0, 1, 2,  0, 4'b1000, 4'b1000, 0, 3,  4};
    tv[8]  = '{"wrap1",    4'b1010, 1'b0, 1, 2,  0, 4'b0010, 4'b0010, 0, 3,  4};
    tv[9]  = '{"to_sol",   4'b0001, 1'b1, 0, 0,  0, 4'b0001, 4'b0000, 1, 16, 17};
    tv[10] = '{"after_to", 4'b0011, 1'b0, 1, 2,  0, 4'b0010, 4'b0010, 0, 3,  4};
    tv[11] = '{"c_at_lim", 4'b1000, 1'b1, 1, 16, 0, 4'b1000, 4'b1000, 0, 17, 18};
    tv[12] = '{"to_esp",   4'b0001, 1'b0, 1, 0,  0, 4'b0001, 4'b0000, 1, 17, 18};
    tv[13] = '{"ae_c",     4'b0010, 1'b0, 1, 1,  4, 4'b0010, 4'b0010, 0, 5,  6};
    fin    = '{"post_rst", 4'b0100, 1'b0, 1, 2,  0, 4'b0100, 4'b0100, 0, 3,  4};
    req = 4'b1111;
    repeat (3) @(negedge clk);
    chk("in_reset.outs", 32'({gnt, done, r_o, busy, err}), 32'd0);
    reset = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    chk("idle.busy", 32'(busy), 32'd0);
    chk("idle.gnt", 32'(gnt), 32'd0);
    foreach (tv[i]) run(tv[i]);
    req = 4'b1111;
    @(negedge clk);
    chk("pre_rst.gnt", 32'(gnt), 32'b0100);
    req = '0;
    a_e_i = 1'b1;
    @(negedge clk);
    a_e_i = 1'b0;
    chk("espera.r_o", 32'(r_o), 32'd0);
    chk("espera.busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1 chk("async_rst.outs", 32'({gnt, done, r_o, busy, err}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    req = 4'b0110;
    @(negedge clk);
    chk("rst_ptr0.gnt", 32'(gnt), 32'b0010);
    req = '0;
    a_e_i = 1'b1;
    @(negedge clk);
    a_e_i = 1'b0;
    c_i = 1'b1;
    @(negedge clk);
    c_i = 1'b0;
    chk("rst_ptr0.done", 32'(done), 32'b0010);
    @(negedge clk);
    chk("rst_ptr0.idle", 32'(busy), 32'd0);
    run(fin);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
